// File: rtl/nt_node_misr_monitor_pkg.sv
// Purpose : shared types and helpers for the node MISR monitor.
// Latency : n/a (package: state enum, default tap constants, MISR step function).
// Backpressure: n/a.
package nt_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  // Default feedback taps for the common signature widths.
  localparam logic [3:0]  POLY_W4  = 4'h3;
  localparam logic [7:0]  POLY_W8  = 8'h1D;
  localparam logic [15:0] POLY_W16 = 16'h002D;

  // One MISR step on a signature of 'width' bits, carried in 32-bit
  // containers so a single function serves every width. Bits above
  // 'width' are masked off in the result.
  function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                            input logic [31:0] obs,
                                            input logic [31:0] poly,
                                            input int unsigned width);
    logic [31:0] top;
    logic [31:0] mask;
    logic [31:0] shifted;
    top     = sig >> (width - 1);
    mask    = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    shifted = sig << 1;
    return (shifted ^ (top[0] ? poly : 32'd0) ^ obs) & mask;
  endfunction

endpackage

// File: rtl/nt_node_misr_monitor_if.sv
// Purpose : bundles the monitor's control, observation and result signals.
// Latency : n/a (wires only); slave = monitor side, master = driver side.
// Backpressure: none; start/abort are level-sampled commands, results are status.
// Ports   : start, abort, obs_in, golden_sig (driver -> monitor);
//           busy, done, mismatch, signature, cycle_cnt, toggle_cnt (monitor -> driver).
interface nt_node_misr_monitor_if #(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 1000
);
  localparam int CW = $clog2(WINDOW + 1);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] obs_in;
  logic [WIDTH-1:0] golden_sig;
  logic             busy;
  logic             done;
  logic             mismatch;
  logic [WIDTH-1:0] signature;
  logic [CW-1:0]    cycle_cnt;
  logic [15:0]      toggle_cnt;

  modport slave (
    input  start, abort, obs_in, golden_sig,
    output busy, done, mismatch, signature, cycle_cnt, toggle_cnt
  );

  modport master (
    output start, abort, obs_in, golden_sig,
    input  busy, done, mismatch, signature, cycle_cnt, toggle_cnt
  );

endinterface

// File: rtl/nt_node_misr_monitor_misr.sv
// Purpose : WIDTH-bit MISR register with load-seed / step / hold controls.
// Latency : new value visible the cycle after load or step; load beats step.
// Backpressure: none; holds when neither load nor step is asserted.
// Ports   : clk, rst (sync, active-high, clears to 0), load, step, obs, sig.
module nt_misr
  import nt_monitor_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(POLY_W8),
  parameter logic [WIDTH-1:0] SEED  = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] obs,
  output logic [WIDTH-1:0] sig
);

  logic [31:0] sig32;
  logic [31:0] obs32;
  logic [31:0] poly32;
  logic [31:0] nxt32;
  logic        unused_hi;

  always_comb begin
    sig32  = '0;
    obs32  = '0;
    poly32 = '0;
    sig32[WIDTH-1:0]  = sig;
    obs32[WIDTH-1:0]  = obs;
    poly32[WIDTH-1:0] = POLY;
    nxt32 = misr_next(sig32, obs32, poly32, WIDTH);
  end

  // Upper container bits are always zero; fold them so nothing dangles.
  assign unused_hi = ^nxt32;

  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= '0;
    end else if (load) begin
      sig <= SEED;
    end else if (step) begin
      sig <= nxt32[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/nt_node_misr_monitor.sv
// Purpose : compacts node outputs into a MISR over a fixed window, then flags signature != golden.
// Latency : done pulses in the cycle after edge WINDOW+1 (start edge = edge 0).
// Backpressure: none; start ignored while busy, abort cancels RUN/CHECK without done.
// Ports   : I1470_clk, I1477_rst (sync, active-high), mon (slave modport of nt_node_misr_monitor_if).
// Option  : NT_MONITOR_TOGGLE_CNT_EN adds a saturating obs_in toggle counter on mon.toggle_cnt.
module nt_node_misr_monitor
  import nt_monitor_pkg::*;
#(
  parameter int               WIDTH  = 8,
  parameter int               WINDOW = 1000,
  parameter logic [WIDTH-1:0] POLY   = WIDTH'(POLY_W8),
  parameter logic [WIDTH-1:0] SEED   = '1
) (
  input  logic                   I1470_clk,
  input  logic                   I1477_rst,
  nt_node_misr_monitor_if.slave  mon
);

  localparam int CW = $clog2(WINDOW + 1);

  state_t           state;
  logic [CW-1:0]    cycle_cnt;
  logic             done;
  logic             mismatch;
  logic             misr_load;
  logic             misr_step;
  logic [WIDTH-1:0] sig;

  // Abort takes priority over the sample step, so an aborted window
  // freezes with the samples taken before the abort edge.
  always_comb begin
    misr_load = 1'b0;
    misr_step = 1'b0;
    if (state == ST_IDLE) misr_load = mon.start;
    if (state == ST_RUN)  misr_step = !mon.abort;
  end

  nt_misr #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk  (I1470_clk),
    .rst  (I1477_rst),
    .load (misr_load),
    .step (misr_step),
    .obs  (mon.obs_in),
    .sig  (sig)
  );

  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) begin
      state     <= ST_IDLE;
      cycle_cnt <= '0;
      done      <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mon.start) begin
            cycle_cnt <= '0;
            mismatch  <= 1'b0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (mon.abort) begin
            state <= ST_IDLE;
          end else begin
            cycle_cnt <= cycle_cnt + CW'(1);
            if (cycle_cnt == CW'(WINDOW - 1)) state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!mon.abort) begin
            mismatch <= (sig != mon.golden_sig);
            done     <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mon.busy      = (state != ST_IDLE);
  assign mon.done      = done;
  assign mon.mismatch  = mismatch;
  assign mon.signature = sig;
  assign mon.cycle_cnt = cycle_cnt;

`ifdef NT_MONITOR_TOGGLE_CNT_EN
  logic [WIDTH-1:0] prev_obs;
  logic [15:0]      tcnt;
  logic [WIDTH-1:0] diff;
  logic [5:0]       pop;
  logic [16:0]      sum;

  always_comb begin
    diff = mon.obs_in ^ prev_obs;
    pop  = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + 6'(diff[i]);
    sum  = {1'b0, tcnt} + 17'(pop);
  end

  // Counts only on real sample edges, mirroring the MISR step.
  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) begin
      prev_obs <= '0;
      tcnt     <= '0;
    end else if (misr_load) begin
      prev_obs <= mon.obs_in;
      tcnt     <= '0;
    end else if (misr_step) begin
      prev_obs <= mon.obs_in;
      tcnt     <= sum[16] ? 16'hFFFF : sum[15:0];
    end
  end

  assign mon.toggle_cnt = tcnt;
`else
  assign mon.toggle_cnt = '0;
`endif

endmodule

// File: doc/nt_node_misr_monitor.md
Name: nt_node_misr_monitor

Overview:
- Downstream observation stage for the Nt_Node subcircuit benchmarks.
- Samples the registered outputs of one or more node subcircuits every clock over a fixed test window and compacts them into a MISR signature.
- At window end, compares the signature against a golden value and flags a mismatch as a trojan-activity indication.
- Sits directly after the subcircuit outputs and feeds the detection-result collector.

Parameters:
- WIDTH, 8, number of observed node outputs; also the MISR/signature width (2..32).
- WINDOW, 1000, sample cycles per test window (>=1).
- POLY, 8'h1D, MISR feedback taps (WIDTH bits; bit i set = tap at bit i).
- SEED, all ones, MISR value loaded at window start.

Ports:
- I1470_clk  in  1  clock; all state updates on rising edge.
- I1477_rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a window; honoured only in IDLE.
- abort  in  1  cancel the current window; honoured in RUN/CHECK.
- obs_in  in  WIDTH  node subcircuit outputs, sampled each RUN cycle.
- golden_sig  in  WIDTH  expected signature; sampled in CHECK.
- busy  out  1  high in RUN and CHECK.
- done  out  1  one-cycle pulse when a window completes normally.
- mismatch  out  1  signature != golden_sig for the last completed window; sticky until the next accepted start.
- signature  out  WIDTH  current/final MISR value.
- cycle_cnt  out  $clog2(WINDOW+1)  samples taken in the current window.
- toggle_cnt  out  16  toggle count (see Optional Feature).

Behaviour:
- Reset (synchronous, active-high) on the edge with I1477_rst=1:
  - state=IDLE, signature=0, cycle_cnt=0, done=0, mismatch=0, busy=0, toggle_cnt=0.
  - Reset wins over every other input, including mid-window; no done pulse is issued.
- States: IDLE, RUN, CHECK.
- IDLE:
  - On an edge with start=1: signature<=SEED, cycle_cnt<=0, mismatch<=0, state<=RUN.
  - abort is ignored in IDLE.
- RUN: each edge performs one MISR step, then cycle_cnt<=cycle_cnt+1.
  - MISR step: signature <= {signature[WIDTH-2:0],1'b0} ^ (signature[WIDTH-1] ? POLY : 0) ^ obs_in.
  - On the edge where cycle_cnt becomes WINDOW, state<=CHECK.
  - Exactly WINDOW samples are taken, on edges 1..WINDOW after the start edge.
- CHECK (one cycle):
  - mismatch<=(signature!=golden_sig), done<=1 for exactly one cycle, state<=IDLE.
  - signature and cycle_cnt hold their values until the next start.
- Latency: done is high in the cycle after edge WINDOW+1, counting the start edge as edge 0.
- start while busy: ignored; no restart, no error.
- abort in RUN or CHECK: state<=IDLE with done=0 and mismatch unchanged; signature and cycle_cnt freeze at their current values.
- Simultaneous start and abort in IDLE: start is accepted.
- busy is combinational from state: (state!=IDLE). done and mismatch are registered.
- No X propagation permitted from obs_in into control; obs_in affects only signature.

Optional Feature:
- Macro: NT_MONITOR_TOGGLE_CNT_EN.
- Defined:
  - A register holds the previous obs_in.
  - Each RUN cycle, toggle_cnt += popcount(obs_in ^ prev); prev is loaded with obs_in on the start edge.
  - The counter saturates at 16'hFFFF and clears on an accepted start.
- Undefined: toggle_cnt tied to 0 and no extra registers.
- The port list is identical in both builds.

Decomposition:
- Package nt_monitor_pkg:
  - State enum (IDLE/RUN/CHECK).
  - Default POLY constants per width (4'h3, 8'h1D, 16'h002D).
  - A function misr_next(sig, obs, poly).
- One sub-module: nt_misr, a WIDTH-bit register with load(SEED)/step/hold controls built on misr_next.
- FSM, counters and the compare stay in the top level.

Test Plan:
1. WIDTH=4, POLY=4'h3, SEED=4'hF, WINDOW=2, obs_in=0, golden_sig=4'h9; pulse start -> signature D then 9; done pulses once 3 edges after start; mismatch=0; cycle_cnt=2.
2. Same setup, golden_sig=4'h8 -> mismatch=1 with the done pulse; mismatch stays 1 until the next start, then clears on the start edge.
3. Start re-asserted every cycle during RUN -> no restart; exactly one done; cycle_cnt reaches WINDOW.
4. Abort after 1 sample -> busy drops next cycle; done never asserts; signature frozen at D; a following start runs a full window.
5. Reset asserted mid-RUN -> next cycle all outputs 0, state IDLE; start is accepted on the first edge after reset deasserts.
6. With NT_MONITOR_TOGGLE_CNT_EN, WIDTH=4: obs_in alternating 4'h0/4'hF over WINDOW=4 -> toggle_cnt=16; without the macro -> toggle_cnt=0.
